// File: rtl/alu_mdu_pkg.sv
// Shared types for the ALU / multiply-divide unit: operation codes and FSM states.
package alu_mdu_pkg;

    localparam int unsigned FUNC_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        FN_ADD   = 4'd0,
        FN_SUB   = 4'd1,
        FN_AND   = 4'd2,
        FN_OR    = 4'd3,
        FN_XOR   = 4'd4,
        FN_NOR   = 4'd5,
        FN_SLT   = 4'd6,
        FN_SLTU  = 4'd7,
        FN_SLL   = 4'd8,
        FN_SRL   = 4'd9,
        FN_SRA   = 4'd10,
        FN_MULT  = 4'd11,
        FN_MULTU = 4'd12,
        FN_DIV   = 4'd13,
        FN_DIVU  = 4'd14,
        FN_RSVD  = 4'd15
    } func_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic is_iter(input func_t f);
        return f inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

    function automatic logic is_div(input func_t f);
        return f inside {FN_DIV, FN_DIVU};
    endfunction

    function automatic logic is_signed_iter(input func_t f);
        return f inside {FN_MULT, FN_DIV};
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/result bundle between a requester (master) and the alu_mdu (slave).
interface alu_mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       func;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             overflow;
    logic             zero;
    logic             equals;
    logic             above;
    logic             err;

    modport master (
        output start, func, op1, op2,
        input  busy, done, result, hi, lo, overflow, zero, equals, above, err
    );

    modport slave (
        input  start, func, op1, op2,
        output busy, done, result, hi, lo, overflow, zero, equals, above, err
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign fix-up applied to the final step.
module alu_mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             div_mode,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             running;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] mb;
    logic             mode_div;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] mb_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] acc_n, q_n;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        a_neg = signed_mode & a[WIDTH-1];
        b_neg = signed_mode & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration step; the last step feeds the outputs combinationally so the
    // caller can register the final answer on the same edge the step completes.
    always_comb begin
        mb_sel  = q[0] ? mb : '0;
        sum     = {1'b0, acc} + {1'b0, mb_sel};
        shifted = {acc, q[WIDTH-1]};
        ge      = (shifted >= {1'b0, mb});
        if (mode_div) begin
            acc_n = ge ? (shifted[WIDTH-1:0] - mb) : shifted[WIDTH-1:0];
            q_n   = {q[WIDTH-2:0], ge};
        end else begin
            acc_n = sum[WIDTH:1];
            q_n   = {sum[0], q[WIDTH-1:1]};
        end

        prod = {acc_n, q_n};
        if (neg_q) prod = -prod;

        if (mode_div) begin
            res_lo = neg_q ? -q_n : q_n;
            res_hi = neg_r ? -acc_n : acc_n;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end

        last = running && (cnt == SHW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running  <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            mb       <= '0;
            mode_div <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (load) begin
            running  <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
            q        <= a_mag;
            mb       <= b_mag;
            mode_div <= div_mode;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
        end else if (running) begin
            acc <= acc_n;
            q   <= q_n;
            cnt <= cnt + 1'b1;
            if (last) running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus iterative multiply/divide behind a start/busy/done handshake.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_mdu_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    func_t            func_in, func_r;
    logic [WIDTH-1:0] op1_r, op2_r;

    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             overflow_q, zero_q, equals_q, above_q, err_q;

    logic             accept;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov, alu_err, alu_zero, alu_eq, alu_above;

    logic             it_last;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic             div0, div_ovf;
    logic [WIDTH-1:0] mdu_hi, mdu_lo;

    assign func_in = func_t'(bus.func);
    assign accept  = bus.start && (state != ST_RUN);

    always_comb begin
        sh      = bus.op2[SHW-1:0];
        sum     = bus.op1 + bus.op2;
        diff    = bus.op1 - bus.op2;
        alu_res = '0;
        alu_ov  = 1'b0;
        alu_err = 1'b0;
        case (func_in)
            FN_ADD: begin
                alu_res = sum;
                alu_ov  = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (sum[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            FN_SUB: begin
                alu_res = diff;
                alu_ov  = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (diff[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            FN_AND:  alu_res = bus.op1 & bus.op2;
            FN_OR:   alu_res = bus.op1 | bus.op2;
            FN_XOR:  alu_res = bus.op1 ^ bus.op2;
            FN_NOR:  alu_res = ~(bus.op1 | bus.op2);
            FN_SLT:  alu_res = WIDTH'($signed(bus.op1) < $signed(bus.op2));
            FN_SLTU: alu_res = WIDTH'(bus.op1 < bus.op2);
            FN_SLL:  alu_res = bus.op1 << sh;
            FN_SRL:  alu_res = bus.op1 >> sh;
            FN_SRA:  alu_res = $signed(bus.op1) >>> sh;
            FN_RSVD: alu_err = 1'b1;
            default: alu_res = '0;
        endcase
        alu_zero  = (func_in != FN_RSVD) && (alu_res == '0);
        alu_eq    = (func_in != FN_RSVD) && (bus.op1 == bus.op2);
        alu_above = (func_in != FN_RSVD) && ($signed(bus.op1) > $signed(bus.op2));
    end

    alu_mdu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (accept && is_iter(func_in)),
        .div_mode    (is_div(func_in)),
        .signed_mode (is_signed_iter(func_in)),
        .a           (bus.op1),
        .b           (bus.op2),
        .last        (it_last),
        .res_hi      (it_hi),
        .res_lo      (it_lo)
    );

    // Most-negative / -1 needs no override: the magnitude path already yields it.
    always_comb begin
        div0    = is_div(func_r) && (op2_r == '0);
        div_ovf = (func_r == FN_DIV) && (op1_r == MOST_NEG) && (op2_r == '1);
        mdu_hi  = div0 ? op1_r : it_hi;
        mdu_lo  = div0 ? '1    : it_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            func_r     <= FN_ADD;
            op1_r      <= '0;
            op2_r      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            equals_q   <= 1'b0;
            above_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        func_r <= func_in;
                        op1_r  <= bus.op1;
                        op2_r  <= bus.op2;
                        if (is_iter(func_in)) begin
                            state  <= ST_RUN;
                            busy_q <= 1'b1;
                        end else begin
                            state      <= ST_DONE;
                            done_q     <= 1'b1;
                            result_q   <= alu_res;
                            overflow_q <= alu_ov;
                            zero_q     <= alu_zero;
                            equals_q   <= alu_eq;
                            above_q    <= alu_above;
                            err_q      <= alu_err;
                        end
                    end
                end
                ST_RUN: begin
                    if (it_last) begin
                        state      <= ST_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        result_q   <= mdu_lo;
                        hi_q       <= mdu_hi;
                        lo_q       <= mdu_lo;
                        overflow_q <= div_ovf;
                        zero_q     <= (mdu_lo == '0);
                        equals_q   <= (op1_r == op2_r);
                        above_q    <= ($signed(op1_r) > $signed(op2_r));
                        err_q      <= div0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
    assign bus.equals   = equals_q;
    assign bus.above    = above_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32): directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_mdu;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(W)) bus ();

    alu_mdu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_fail = 0;

    logic [31:0] m_res, m_hi, m_lo;
    logic        m_ov, m_zero, m_eq, m_ab, m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: wide integer arithmetic; hi/lo persist across non-mul/div ops.
    task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, r, qq, rr;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        m_ov  = 1'b0;
        m_err = 1'b0;
        m_res = 32'd0;
        case (f)
            4'd0:  begin r = sa + sb; m_res = 32'(r); m_ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd1:  begin r = sa - sb; m_res = 32'(r); m_ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'd2:  m_res = a & b;
            4'd3:  m_res = a | b;
            4'd4:  m_res = a ^ b;
            4'd5:  m_res = ~(a | b);
            4'd6:  m_res = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  m_res = (ua < ub) ? 32'd1 : 32'd0;
            4'd8:  m_res = a << b[4:0];
            4'd9:  m_res = a >> b[4:0];
            4'd10: m_res = 32'(sa >>> b[4:0]);
            4'd11: begin r = sa * sb; m_hi = r[63:32]; m_lo = r[31:0]; m_res = m_lo; end
            4'd12: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; m_res = m_lo; end
            4'd13, 4'd14: begin
                if (b == 32'd0) begin
                    m_err = 1'b1;
                    m_lo  = 32'hFFFF_FFFF;
                    m_hi  = a;
                end else if (f == 4'd13) begin
                    qq = sa / sb;
                    rr = sa % sb;
                    m_ov = (qq > 64'sd2147483647);
                    m_lo = 32'(qq);
                    m_hi = 32'(rr);
                end else begin
                    m_lo = 32'(ua / ub);
                    m_hi = 32'(ua % ub);
                end
                m_res = m_lo;
            end
            default: m_err = 1'b1;
        endcase
        m_zero = (f != 4'd15) && (m_res == 32'd0);
        m_eq   = (f != 4'd15) && (a == b);
        m_ab   = (f != 4'd15) && (sa > sb);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, " result"}, 64'(bus.result), 64'(m_res));
        chk({tag, " hi"},     64'(bus.hi),     64'(m_hi));
        chk({tag, " lo"},     64'(bus.lo),     64'(m_lo));
        chk({tag, " flags"},  64'({bus.overflow, bus.zero, bus.equals, bus.above, bus.err}),
                              64'({m_ov, m_zero, m_eq, m_ab, m_err}));
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat, busy_n, exp_lat;
        bit seen;
        model(f, a, b);
        exp_lat = (f >= 4'd11 && f <= 4'd14) ? 33 : 1;
        @(negedge clk);
        bus.start = 1'b1; bus.func = f; bus.op1 = a; bus.op2 = b;
        seen = 1'b0; lat = 0; busy_n = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.op1   = $urandom;
            bus.op2   = $urandom;
            bus.func  = 4'($urandom);
            if (bus.busy) busy_n++;
            if (bus.done) begin seen = 1'b1; lat = c; end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        chk({tag, " busy at done"}, 64'(bus.busy), 64'd0);
        chk_outputs(tag);
        @(negedge clk);
        chk({tag, " done drops"}, 64'(bus.done), 64'd0);
        chk({tag, " result held"}, 64'(bus.result), 64'(m_res));
    endtask

    initial begin
        int done_n, busy_n;
        bit seen;
        bus.start = 1'b0; bus.func = 4'd0; bus.op1 = '0; bus.op2 = '0;
        m_hi = 32'd0; m_lo = 32'd0;

        #2;
        chk("reset busy/done", 64'({bus.busy, bus.done}), 64'd0);
        chk("reset result", 64'(bus.result), 64'd0);
        chk("reset hi/lo", 64'({bus.hi, bus.lo}), 64'd0);
        chk("reset flags", 64'({bus.overflow, bus.zero, bus.equals, bus.above, bus.err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
        chk("add ovf const", 64'({bus.result, bus.overflow, bus.zero}), {32'h0, 32'h8000_0000, 2'b10} >> 0 & 64'h3_FFFF_FFFF);
        run_op("sub", 4'd1, 32'h8000_0000, 32'd1);
        run_op("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
        run_op("or",  4'd3, 32'hF0F0_0000, 32'h0000_00FF);
        run_op("xor", 4'd4, 32'hAAAA_5555, 32'hAAAA_5555);
        run_op("nor", 4'd5, 32'h0000_0000, 32'h0000_0000);
        run_op("slt", 4'd6, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1);
        run_op("sll", 4'd8, 32'h0000_0001, 32'hFFFF_FFFF);
        run_op("srl", 4'd9, 32'h8000_0000, 32'd31);
        run_op("rsvd", 4'd15, 32'd5, 32'd5);

        run_op("mult", 4'd11, 32'hFFFF_FFFD, 32'd7);
        chk("mult const", 64'({bus.hi, bus.lo}), 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("multu", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div", 4'd13, 32'hFFFF_FFF9, 32'd2);
        chk("div const", 64'({bus.hi, bus.lo}), 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu by 0", 4'd14, 32'd100, 32'd0);
        chk("divu0 const", 64'({bus.err, bus.hi, bus.lo}), {1'b1, 32'd100, 32'hFFFF_FFFF} & 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div ovf const", 64'({bus.overflow, bus.hi, bus.lo}), {1'b1, 32'd0, 32'h8000_0000} & 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div 0/x", 4'd13, 32'd0, 32'hFFFF_FFF0);

        // Starts during RUN are ignored; a start in the done cycle is accepted.
        model(4'd11, 32'd1234, 32'hFFFF_D8F0);
        @(negedge clk);
        bus.start = 1'b1; bus.func = 4'd11; bus.op1 = 32'd1234; bus.op2 = 32'hFFFF_D8F0;
        seen = 1'b0; done_n = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            bus.start = (c == 3) || (c == 10) || (c == 20);
            bus.op1   = $urandom;
            bus.func  = 4'($urandom);
            if (bus.done) begin seen = 1'b1; done_n = c; end
        end
        chk("run ignore latency", 64'(done_n), 64'd33);
        chk_outputs("run ignore");
        model(4'd1, 32'd5, 32'd5);
        bus.start = 1'b1; bus.func = 4'd1; bus.op1 = 32'd5; bus.op2 = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b done", 64'(bus.done), 64'd1);
        chk_outputs("b2b sub");
        chk("b2b zero/eq", 64'({bus.zero, bus.equals}), 64'd3);

        // Reset mid-multiply aborts with no trailing done.
        model(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        bus.start = 1'b1; bus.func = 4'd12; bus.op1 = 32'h1234_5678; bus.op2 = 32'h9ABC_DEF0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        m_res = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
        m_ov = 1'b0; m_zero = 1'b0; m_eq = 1'b0; m_ab = 1'b0; m_err = 1'b0;
        chk("abort busy/done", 64'({bus.busy, bus.done}), 64'd0);
        chk_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) done_n++;
            if (bus.busy) busy_n++;
        end
        chk("abort no done", 64'(done_n), 64'd0);
        chk("abort no busy", 64'(busy_n), 64'd0);
        run_op("sra", 4'd10, 32'h8000_0000, 32'd4);
        chk("sra const", 64'(bus.result), 64'hF800_0000);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  f;
            logic [31:0] a, b;
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = a;
                2: b = 32'($urandom_range(0, 40));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op("random", f, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
